// File: rtl/key_schedule_ctrl.sv
// key_schedule_ctrl - iterative AES-128 key-schedule sequencer.
//
// Accepts a cipher key over a valid/ready handshake. It then produces one
// round key per cycle with a combinational KeyExpansion round function. The
// round function reads a feedback register, so it never reads the key file.
// Every round key, including round 0 (the cipher key), goes into a key file
// with NR+1 entries. A registered read port reads the file by index.
//
// Byte layout: a 128-bit key is [0:127], and bits [8*i : 8*i+7] hold AES
// byte i. Word w0 is bits [0:31].
//
// Parameters:
//   NR           number of expansion rounds (1..10); key file indices 0..NR
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   key_valid    cipher key offered          key_ready   key can be accepted
//   key_in       cipher key                  busy        expansion running
//   keys_valid   all NR+1 round keys stored and stable
//   rk_rd_en     read request                rk_rd_idx   round-key index
//   rk_rd_data   registered read data        rk_rd_valid read data valid
//   rk_rd_err    read rejected (keys not valid or index > NR)
//
// Optional feature (macro KEY_SCHED_RESTART_EN): key_ready stays high
// during EXPAND. A new key accepted there restarts the expansion from
// round 1.
module key_schedule_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [0:127] key_in,
  output logic         busy,
  output logic         keys_valid,
  input  logic         rk_rd_en,
  input  logic [3:0]   rk_rd_idx,
  output logic [0:127] rk_rd_data,
  output logic         rk_rd_valid,
  output logic         rk_rd_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam logic [3:0] NR_L     = 4'(NR);

  // GF(2^8) multiply, modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box computed, not looked up: the inverse is x^254 (squares x^2..x^128
  // multiplied together), followed by the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] inv;
    p   = x;
    inv = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // KeyExpansion round function: previous round key plus round number
  // (keyInit) gives the next round key.
  function automatic logic [0:127] key_expand(input logic [0:127] k, input logic [3:0] rnd);
    logic [0:31]  t;
    logic [0:127] n;
    t = {sbox(k[104:111]), sbox(k[112:119]), sbox(k[120:127]), sbox(k[96:103])}
        ^ {rcon(rnd), 24'h000000};
    n[0:31]   = k[0:31]   ^ t;
    n[32:63]  = k[32:63]  ^ n[0:31];
    n[64:95]  = k[64:95]  ^ n[32:63];
    n[96:127] = k[96:127] ^ n[64:95];
    return n;
  endfunction

  logic [1:0]   state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [0:127] fb_q, fb_d;
  logic [0:127] rk_q [0:NR];
  logic         rk_we;
  logic [3:0]   rk_waddr;
  logic [0:127] rk_wdata;
  logic [0:127] round_key;
  logic [0:127] rd_data_q, rd_data_d;
  logic         rd_valid_q, rd_valid_d;
  logic         rd_err_q, rd_err_d;
  logic         accept;

`ifdef KEY_SCHED_RESTART_EN
  assign key_ready = 1'b1;
`else
  assign key_ready = (state_q != S_EXPAND);
`endif

  assign busy        = (state_q == S_EXPAND);
  assign keys_valid  = (state_q == S_DONE);
  assign accept      = key_valid && key_ready;
  assign rk_rd_data  = rd_data_q;
  assign rk_rd_valid = rd_valid_q;
  assign rk_rd_err   = rd_err_q;

  always_comb round_key = key_expand(fb_q, round_q);

  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    fb_d     = fb_q;
    rk_we    = 1'b0;
    rk_waddr = round_q;
    rk_wdata = round_key;
    if (accept) begin
      // A key accepted in EXPAND (restart build only) takes priority over
      // the round write that would otherwise happen on this edge.
      state_d  = S_EXPAND;
      round_d  = 4'd1;
      fb_d     = key_in;
      rk_we    = 1'b1;
      rk_waddr = '0;
      rk_wdata = key_in;
    end else if (state_q == S_EXPAND) begin
      rk_we = 1'b1;
      fb_d  = round_key;
      if (round_q == NR_L) begin
        // Hold the counter at NR, so it stays within 1..NR.
        state_d = S_DONE;
      end else begin
        round_d = round_q + 4'd1;
      end
    end
  end

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_err_d   = 1'b0;
    if (rk_rd_en) begin
      if (keys_valid && (rk_rd_idx <= NR_L)) begin
        rd_data_d  = rk_q[rk_rd_idx];
        rd_valid_d = 1'b1;
      end else begin
        rd_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      round_q    <= '0;
      fb_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      round_q    <= round_d;
      fb_q       <= fb_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
    end
  end

  // The key file has no reset. keys_valid masks it, and rst blocks writes,
  // so a reset during expansion leaves no trailing write.
  always_ff @(posedge clk) begin
    if (!rst && rk_we) rk_q[rk_waddr] <= rk_wdata;
  end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
module tb_key_schedule_ctrl;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         key_valid = 1'b0, rk_rd_en = 1'b0;
  logic [0:127] key_in = '0;
  logic [3:0]   rk_rd_idx = '0;
  logic         key_ready, busy, keys_valid, rk_rd_valid, rk_rd_err;
  logic [0:127] rk_rd_data;

  logic         key_valid4 = 1'b0, rk_rd_en4 = 1'b0;
  logic [0:127] key_in4 = '0;
  logic [3:0]   rk_rd_idx4 = '0;
  logic         key_ready4, busy4, keys_valid4, rk_rd_valid4, rk_rd_err4;
  logic [0:127] rk_rd_data4;

  key_schedule_ctrl dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready),
    .key_in(key_in), .busy(busy), .keys_valid(keys_valid),
    .rk_rd_en(rk_rd_en), .rk_rd_idx(rk_rd_idx), .rk_rd_data(rk_rd_data),
    .rk_rd_valid(rk_rd_valid), .rk_rd_err(rk_rd_err)
  );

  key_schedule_ctrl #(.NR(4)) dut4 (
    .clk(clk), .rst(rst), .key_valid(key_valid4), .key_ready(key_ready4),
    .key_in(key_in4), .busy(busy4), .keys_valid(keys_valid4),
    .rk_rd_en(rk_rd_en4), .rk_rd_idx(rk_rd_idx4), .rk_rd_data(rk_rd_data4),
    .rk_rd_valid(rk_rd_valid4), .rk_rd_err(rk_rd_err4)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]   sbox_t   [0:255];
  logic [127:0] model_rk [0:10];
  logic [127:0] exp_data = '0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc, aa;
    acc = '0;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xt(aa);
    end
    return acc;
  endfunction

  // S-box from its definition: brute-force inverse, then the bitwise affine map.
  task automatic init_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
      sbox_t[x] = s;
    end
  endtask

  // Word-oriented key expansion with 44 words, giving round keys 0..10.
  task automatic expand_ref(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input int idx);
    rk_rd_en  = 1'b1;
    rk_rd_idx = 4'(idx);
    tick();
    rk_rd_en  = 1'b0;
  endtask

  task automatic do_read4(input int idx);
    rk_rd_en4  = 1'b1;
    rk_rd_idx4 = 4'(idx);
    tick();
    rk_rd_en4  = 1'b0;
  endtask

  // Present a key for one edge. On return the bench is in cycle T+1.
  task automatic load_key(input logic [127:0] k);
    key_valid = 1'b1;
    key_in    = k;
    total++;
    if (key_ready !== 1'b1) begin bad++; $display("FAIL load_ready: got %b want 1", key_ready); end
    tick();
    key_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int n;
    n = 0;
    while (keys_valid !== 1'b1 && n < max_cyc) begin tick(); n++; end
    total++;
    if (keys_valid !== 1'b1) begin bad++; $display("FAIL wait_done: keys_valid=%b after %0d cycles want 1", keys_valid, n); end
  endtask

  task automatic read_all_check(input string tag);
    for (int i = 0; i < 11; i++) begin
      do_read(i);
      total++;
      if (rk_rd_valid !== 1'b1 || rk_rd_data !== model_rk[i]) begin
        bad++;
        $display("FAIL %s idx%0d: got v=%b %h want v=1 %h", tag, i, rk_rd_valid, rk_rd_data, model_rk[i]);
      end
    end
    exp_data = model_rk[10];
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    total++;
    if ({busy, keys_valid, rk_rd_valid, rk_rd_err} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags: got %b want 0000", {busy, keys_valid, rk_rd_valid, rk_rd_err});
    end
    total++;
    if (rk_rd_data !== 128'h0) begin bad++; $display("FAIL reset_data: got %h want 0", rk_rd_data); end
    total++;
    if (key_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", key_ready); end
    total++;
    if ({key_ready4, busy4, keys_valid4} !== 3'b100) begin
      bad++; $display("FAIL reset_nr4: got %b want 100", {key_ready4, busy4, keys_valid4});
    end
  endtask

  task automatic test_fips();
    expand_ref(FIPS_KEY);
    load_key(FIPS_KEY);
    for (int c = 1; c <= 10; c++) begin
      total++;
      if (busy !== 1'b1 || keys_valid !== 1'b0) begin
        bad++; $display("FAIL fips_busy T+%0d: got busy=%b kv=%b want 1 0", c, busy, keys_valid);
      end
      tick();
    end
    total++;
    if ({keys_valid, busy, key_ready} !== 3'b101) begin
      bad++; $display("FAIL fips_done T+11: got kv/busy/rdy=%b want 101", {keys_valid, busy, key_ready});
    end
    do_read(1);
    total++;
    if (rk_rd_valid !== 1'b1 || rk_rd_err !== 1'b0 || rk_rd_data !== FIPS_RK1) begin
      bad++; $display("FAIL fips_rk1: got v=%b e=%b %h want 1 0 %h", rk_rd_valid, rk_rd_err, rk_rd_data, FIPS_RK1);
    end
    do_read(10);
    total++;
    if (rk_rd_valid !== 1'b1 || rk_rd_data !== FIPS_RK10) begin
      bad++; $display("FAIL fips_rk10: got v=%b %h want 1 %h", rk_rd_valid, rk_rd_data, FIPS_RK10);
    end
    read_all_check("fips_all");
  endtask

  task automatic test_bad_reads();
    int idxs [2] = '{11, 15};
    foreach (idxs[k]) begin
      do_read(idxs[k]);
      total++;
      if (rk_rd_err !== 1'b1 || rk_rd_valid !== 1'b0 || rk_rd_data !== exp_data) begin
        bad++; $display("FAIL bad_idx%0d: got e=%b v=%b %h want 1 0 %h", idxs[k], rk_rd_err, rk_rd_valid, rk_rd_data, exp_data);
      end
    end
    tick();
    total++;
    if (rk_rd_err !== 1'b0 || rk_rd_valid !== 1'b0 || rk_rd_data !== exp_data) begin
      bad++; $display("FAIL idle_read: got e=%b v=%b %h want 0 0 %h", rk_rd_err, rk_rd_valid, rk_rd_data, exp_data);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] k;
    k = rand128();
    expand_ref(k);
    load_key(k);               // cycle T+1
    tick();                    // cycle T+2
    do_read(3);                // cycle T+3
    total++;
    if (rk_rd_err !== 1'b1 || rk_rd_valid !== 1'b0 || rk_rd_data !== exp_data) begin
      bad++; $display("FAIL early_read: got e=%b v=%b %h want 1 0 %h", rk_rd_err, rk_rd_valid, rk_rd_data, exp_data);
    end
    tick(); tick();            // cycle T+5
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({busy, keys_valid, key_ready} !== 3'b001) begin
      bad++; $display("FAIL mid_reset: got busy/kv/rdy=%b want 001", {busy, keys_valid, key_ready});
    end
    total++;
    if (rk_rd_data !== 128'h0) begin bad++; $display("FAIL mid_reset_data: got %h want 0", rk_rd_data); end
    load_key(k);
    wait_done(15);
    read_all_check("reload");
  endtask

  task automatic test_back_to_back();
    logic [127:0] a0, b;
    a0 = model_rk[0];
    b  = rand128();
    key_valid = 1'b1; key_in = b;
    rk_rd_en  = 1'b1; rk_rd_idx = 4'd0;
    total++;
    if (keys_valid !== 1'b1 || key_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_pre: got kv=%b rdy=%b want 1 1", keys_valid, key_ready);
    end
    tick();                    // cycle T+1
    key_valid = 1'b0; rk_rd_en = 1'b0;
    total++;
    if (rk_rd_valid !== 1'b1 || rk_rd_data !== a0) begin
      bad++; $display("FAIL b2b_old: got v=%b %h want 1 %h", rk_rd_valid, rk_rd_data, a0);
    end
    expand_ref(b);
    for (int c = 1; c <= 10; c++) begin
      total++;
      if (keys_valid !== 1'b0) begin bad++; $display("FAIL b2b_kv T+%0d: got %b want 0", c, keys_valid); end
      tick();
    end
    total++;
    if (keys_valid !== 1'b1) begin bad++; $display("FAIL b2b_done: got %b want 1", keys_valid); end
    read_all_check("b2b_new");
  endtask

  task automatic test_hold_valid();
    logic [127:0] a, c;
    logic [127:0] a10;
    a = rand128();
    c = rand128();
    expand_ref(a);
    a10 = model_rk[10];
    load_key(a);               // cycle T+1
    key_valid = 1'b1; key_in = c;
`ifdef KEY_SCHED_RESTART_EN
    total++;
    if (key_ready !== 1'b1) begin bad++; $display("FAIL restart_ready: got %b want 1", key_ready); end
    tick();                    // accepted at edge T+1, cycle T+2
    key_valid = 1'b0;
    expand_ref(c);
    for (int n = 2; n <= 11; n++) begin
      total++;
      if (busy !== 1'b1 || keys_valid !== 1'b0) begin
        bad++; $display("FAIL restart_busy T+%0d: got busy=%b kv=%b want 1 0", n, busy, keys_valid);
      end
      tick();
    end
    total++;
    if (keys_valid !== 1'b1) begin bad++; $display("FAIL restart_done: got %b want 1", keys_valid); end
`else
    for (int n = 1; n <= 10; n++) begin
      total++;
      if (key_ready !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL hold_ready T+%0d: got rdy=%b busy=%b want 0 1", n, key_ready, busy);
      end
      tick();
    end
    total++;
    if (keys_valid !== 1'b1 || key_ready !== 1'b1) begin
      bad++; $display("FAIL hold_done: got kv=%b rdy=%b want 1 1", keys_valid, key_ready);
    end
    rk_rd_en = 1'b1; rk_rd_idx = 4'd10;
    tick();                    // C accepted here, read sees A
    key_valid = 1'b0; rk_rd_en = 1'b0;
    total++;
    if (rk_rd_valid !== 1'b1 || rk_rd_data !== a10) begin
      bad++; $display("FAIL hold_old_rk10: got v=%b %h want 1 %h", rk_rd_valid, rk_rd_data, a10);
    end
    expand_ref(c);
    wait_done(15);
`endif
    do_read(10);
    total++;
    if (rk_rd_valid !== 1'b1 || rk_rd_data !== model_rk[10]) begin
      bad++; $display("FAIL hold_new_rk10: got v=%b %h want 1 %h", rk_rd_valid, rk_rd_data, model_rk[10]);
    end
  endtask

  task automatic test_nr4();
    logic [127:0] k;
    k = rand128();
    expand_ref(k);
    key_valid4 = 1'b1; key_in4 = k;
    total++;
    if (key_ready4 !== 1'b1) begin bad++; $display("FAIL nr4_ready: got %b want 1", key_ready4); end
    tick();
    key_valid4 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      total++;
      if (busy4 !== 1'b1 || keys_valid4 !== 1'b0) begin
        bad++; $display("FAIL nr4_busy T+%0d: got busy=%b kv=%b want 1 0", c, busy4, keys_valid4);
      end
      tick();
    end
    total++;
    if (keys_valid4 !== 1'b1 || busy4 !== 1'b0) begin
      bad++; $display("FAIL nr4_done: got kv=%b busy=%b want 1 0", keys_valid4, busy4);
    end
    for (int i = 0; i <= 4; i++) begin
      do_read4(i);
      total++;
      if (rk_rd_valid4 !== 1'b1 || rk_rd_data4 !== model_rk[i]) begin
        bad++; $display("FAIL nr4_idx%0d: got v=%b %h want 1 %h", i, rk_rd_valid4, rk_rd_data4, model_rk[i]);
      end
    end
    do_read4(5);
    total++;
    if (rk_rd_err4 !== 1'b1 || rk_rd_valid4 !== 1'b0 || rk_rd_data4 !== model_rk[4]) begin
      bad++; $display("FAIL nr4_idx5: got e=%b v=%b %h want 1 0 %h", rk_rd_err4, rk_rd_valid4, rk_rd_data4, model_rk[4]);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    init_sbox();
    test_reset();
    test_fips();
    test_bad_reads();
    test_reset_mid();
    test_back_to_back();
    test_hold_valid();
    test_nr4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
